// File: rtl/majority_pkg.sv
// ============================================================================
// Package : majority_pkg
// Shared definitions for the sequential majority voter: filter FSM state
// encoding, popcount width helper and the tie-break default used on the
// very first sample.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package majority_pkg;

  // Filter FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_INIT   = 2'd0;
  localparam state_t ST_STABLE = 2'd1;
  localparam state_t ST_PEND   = 2'd2;

  // Decision taken when the very first sample is an exact tie
  localparam logic TIE_DEFAULT = 1'b0;

  // Bits needed to hold a popcount of n inputs (0..n)
  function automatic int popcnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/popcount_n.sv
// ============================================================================
// Module  : popcount_n
// Pure combinational population count of an N-bit vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_n
  import majority_pkg::*;
#(
  parameter int N  = 5,
  parameter int OW = popcnt_w(N)
) (
  input  logic [N-1:0]  data_i,
  output logic [OW-1:0] ones_o
);

  // Sum of all set bits
  always_comb begin
    ones_o = '0;
    for (int i = 0; i < N; i++) begin
      ones_o = ones_o + OW'(data_i[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/majority_voter_seq.sv
// ============================================================================
// Module  : majority_voter_seq
// N-input majority voter with valid/ready stream interface, one-entry output
// register and a HOLD-sample persistence filter on the voted bit. Ties hold
// the previous decision.
// Optional feature macro: MAJORITY_STATS_EN adds stats_clr/err_cnt, a
// saturating count of non-unanimous accepted samples.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module majority_voter_seq
  import majority_pkg::*;
#(
  parameter int N     = 5,
  parameter int HOLD  = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_vote,
  output logic [popcnt_w(N)-1:0]   out_ones,
  output logic                     out_tie,
`ifdef MAJORITY_STATS_EN
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         err_cnt,
`endif
  output logic                     stable
);

  localparam int OW  = popcnt_w(N);
  localparam int OW1 = OW + 1;
  localparam int CW  = $clog2(HOLD + 1);

  localparam logic [OW:0]   C_N    = OW1'(N);
  localparam logic [OW-1:0] C_ALL  = OW'(N);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(HOLD - 1);

  logic [OW-1:0] w_ones;
  logic [OW:0]   w_twice;
  logic          w_gt;
  logic          w_tie;
  logic          w_raw;
  logic          w_accept;

  state_t        state_q, state_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          out_valid_q;
  logic          out_vote_q;
  logic [OW-1:0] out_ones_q;
  logic          out_tie_q;

  popcount_n #(.N(N), .OW(OW)) u_popcount (
    .data_i (in_data),
    .ones_o (w_ones)
  );

  assign w_twice  = {w_ones, 1'b0};
  assign w_gt     = (w_twice > C_N);
  assign w_tie    = (w_twice == C_N);
  // A tie keeps whatever the filter currently says
  assign w_raw    = w_tie ? filt_q : w_gt;

  // Depends only on registered state, so no in_valid -> in_ready path
  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  // Persistence filter next-state; advances only on accepted samples
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      case (state_q)
        ST_INIT: begin
          filt_d  = w_tie ? TIE_DEFAULT : w_gt;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
        ST_STABLE: begin
          if (w_raw != filt_q) begin
            if (HOLD == 1) begin
              filt_d = ~filt_q;
            end else begin
              cnt_d   = C_ONE;
              state_d = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (w_raw == filt_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == C_LAST) begin
            filt_d  = ~filt_q;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-entry result register; a new accept overrides a same-cycle consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_vote_q  <= 1'b0;
      out_ones_q  <= '0;
      out_tie_q   <= 1'b0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_vote_q  <= filt_d;
      out_ones_q  <= w_ones;
      out_tie_q   <= w_tie;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vote  = out_vote_q;
  assign out_ones  = out_ones_q;
  assign out_tie   = out_tie_q;
  assign stable    = (state_q == ST_STABLE);

`ifdef MAJORITY_STATS_EN
  localparam logic [CNT_W-1:0] C_ERR_MAX = '1;
  logic             w_mixed;
  logic [CNT_W-1:0] err_q;

  assign w_mixed = (w_ones != '0) && (w_ones != C_ALL);

  // Saturating count of non-unanimous samples; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (stats_clr) begin
      err_q <= '0;
    end else if (w_accept && w_mixed && (err_q != C_ERR_MAX)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_majority_voter_seq.sv
// ============================================================================
// Module  : tb_majority_voter_seq
// Scoreboard bench for majority_voter_seq: an N=5 and an N=4 instance, both
// HOLD=3, CNT_W=2. Directed samples push hand-computed results; monitors pop
// and compare whenever a result is consumed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_majority_voter_seq;

  typedef struct packed {
    logic       vote;
    logic [2:0] ones;
    logic       tie;
    logic       stable;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stats_clr = 1'b0;

  logic       in_valid5 = 1'b0, in_ready5, out_valid5, out_ready5 = 1'b1;
  logic [4:0] in_data5 = '0;
  logic       out_vote5, out_tie5, stable5;
  logic [2:0] out_ones5;
  logic [1:0] err_cnt5;

  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0] in_data4 = '0;
  logic       out_vote4, out_tie4, stable4;
  logic [2:0] out_ones4;
  logic [1:0] err_cnt4;

  exp_t q5[$];
  exp_t q4[$];
  exp_t e5, e4;
  int   total = 0;
  int   bad = 0;
  longint t0;

  majority_voter_seq #(.N(5), .HOLD(3), .CNT_W(2)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid5),
    .in_data   (in_data5),
    .in_ready  (in_ready5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_vote  (out_vote5),
    .out_ones  (out_ones5),
    .out_tie   (out_tie5),
`ifdef MAJORITY_STATS_EN
    .stats_clr (stats_clr),
    .err_cnt   (err_cnt5),
`endif
    .stable    (stable5)
  );

  majority_voter_seq #(.N(4), .HOLD(3), .CNT_W(2)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_data   (in_data4),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_vote  (out_vote4),
    .out_ones  (out_ones4),
    .out_tie   (out_tie4),
`ifdef MAJORITY_STATS_EN
    .stats_clr (1'b0),
    .err_cnt   (err_cnt4),
`endif
    .stable    (stable4)
  );

`ifndef MAJORITY_STATS_EN
  assign err_cnt5 = '0;
  assign err_cnt4 = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a sample, wait (bounded) for acceptance, record its expected result
  task automatic send5(input logic [4:0] d, input logic v, input logic [2:0] o,
                       input logic t, input logic s);
    int waited = 0;
    in_valid5 = 1'b1;
    in_data5  = d;
    @(negedge clk);
    while (!in_ready5 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready5) begin
      total++;
      bad++;
      $display("FAIL accept5_timeout: in_ready got 0 expected 1");
    end else begin
      @(posedge clk);
      q5.push_back(exp_t'{v, o, t, s});
      #1;
    end
  endtask

  task automatic send4(input logic [3:0] d, input logic v, input logic [2:0] o,
                       input logic t, input logic s);
    int waited = 0;
    in_valid4 = 1'b1;
    in_data4  = d;
    @(negedge clk);
    while (!in_ready4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready4) begin
      total++;
      bad++;
      $display("FAIL accept4_timeout: in_ready got 0 expected 1");
    end else begin
      @(posedge clk);
      q4.push_back(exp_t'{v, o, t, s});
      #1;
    end
  endtask

  task automatic idle5(input int n);
    in_valid5 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle4(input int n);
    in_valid4 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for N=5: compare each result as it is consumed
  always @(negedge clk) begin
    if (rst_n && out_valid5 && out_ready5) begin
      total++;
      if (q5.size() == 0) begin
        bad++;
        $display("FAIL mon5_unexpected: got vote=%0d ones=%0d expected no result", out_vote5, out_ones5);
      end else begin
        e5 = q5.pop_front();
        if ({out_vote5, out_ones5, out_tie5, stable5} != e5) begin
          bad++;
          $display("FAIL mon5_result: got vote=%0d ones=%0d tie=%0d stable=%0d expected vote=%0d ones=%0d tie=%0d stable=%0d",
                   out_vote5, out_ones5, out_tie5, stable5, e5.vote, e5.ones, e5.tie, e5.stable);
        end
      end
    end
  end

  // Monitor for N=4
  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL mon4_unexpected: got vote=%0d ones=%0d expected no result", out_vote4, out_ones4);
      end else begin
        e4 = q4.pop_front();
        if ({out_vote4, out_ones4, out_tie4, stable4} != e4) begin
          bad++;
          $display("FAIL mon4_result: got vote=%0d ones=%0d tie=%0d stable=%0d expected vote=%0d ones=%0d tie=%0d stable=%0d",
                   out_vote4, out_ones4, out_tie4, stable4, e4.vote, e4.ones, e4.tie, e4.stable);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid5, 0);
    chk("rst_out_vote", out_vote5, 0);
    chk("rst_out_ones", out_ones5, 0);
    chk("rst_out_tie", out_tie5, 0);
    chk("rst_stable", stable5, 0);
    chk("rst_in_ready", in_ready5, 1);
    chk("rst_err_cnt", err_cnt5, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First sample initialises the filter
    send5(5'b11100, 1'b1, 3'd3, 1'b0, 1'b1);
    // Glitch rejected, agreement returns to stable, new disagreement pends
    send5(5'b00001, 1'b1, 3'd1, 1'b0, 1'b0);
    send5(5'b11111, 1'b1, 3'd5, 1'b0, 1'b1);
    send5(5'b00000, 1'b1, 3'd0, 1'b0, 1'b0);
    send5(5'b11111, 1'b1, 3'd5, 1'b0, 1'b1);
    // Three consecutive disagreeing samples flip the vote
    send5(5'b00011, 1'b1, 3'd2, 1'b0, 1'b0);
    send5(5'b00011, 1'b1, 3'd2, 1'b0, 1'b0);
    send5(5'b00011, 1'b0, 3'd2, 1'b0, 1'b1);
    idle5(3);

    // Backpressure: result held, FSM frozen, input stalled
    out_ready5 = 1'b0;
    send5(5'b11100, 1'b0, 3'd3, 1'b0, 1'b0);
    in_valid5 = 1'b1;
    in_data5  = 5'b11110;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready5, 0);
      chk("bp_out_valid", out_valid5, 1);
      chk("bp_out_ones", out_ones5, 3);
      chk("bp_stable", stable5, 0);
    end
    @(posedge clk);
    #1;
    out_ready5 = 1'b1;
    t0 = $time;
    send5(5'b11110, 1'b0, 3'd4, 1'b0, 1'b0);
    send5(5'b11111, 1'b1, 3'd5, 1'b0, 1'b1);
    send5(5'b00000, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("throughput_cycles", int'(($time - t0) / 10), 3);
    idle5(2);

    // Asynchronous reset while a result is held
    out_ready5 = 1'b0;
    send5(5'b00111, 1'b1, 3'd3, 1'b0, 1'b1);
    in_valid5 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid5, 0);
    chk("midrst_out_vote", out_vote5, 0);
    chk("midrst_out_ones", out_ones5, 0);
    chk("midrst_stable", stable5, 0);
    chk("midrst_in_ready", in_ready5, 1);
    chk("midrst_err_cnt", err_cnt5, 0);
    q5.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready5 = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset stream with mixed samples for the statistics counter
    send5(5'b00011, 1'b0, 3'd2, 1'b0, 1'b1);
    send5(5'b11111, 1'b0, 3'd5, 1'b0, 1'b0);
    send5(5'b01000, 1'b0, 3'd1, 1'b0, 1'b1);
    send5(5'b11110, 1'b0, 3'd4, 1'b0, 1'b0);
`ifdef MAJORITY_STATS_EN
    chk("err_cnt_three", err_cnt5, 3);
`endif
    send5(5'b10101, 1'b0, 3'd3, 1'b0, 1'b0);
    send5(5'b00000, 1'b0, 3'd0, 1'b0, 1'b1);
`ifdef MAJORITY_STATS_EN
    chk("err_cnt_saturated", err_cnt5, 3);
`endif
    stats_clr = 1'b1;
    send5(5'b00001, 1'b0, 3'd1, 1'b0, 1'b1);
    stats_clr = 1'b0;
`ifdef MAJORITY_STATS_EN
    chk("err_cnt_clear_wins", err_cnt5, 0);
`endif
    idle5(3);

    // Even N: first-sample tie defaults to 0, later ties hold the vote
    send4(4'b0011, 1'b0, 3'd2, 1'b1, 1'b1);
    send4(4'b1111, 1'b0, 3'd4, 1'b0, 1'b0);
    send4(4'b1111, 1'b0, 3'd4, 1'b0, 1'b0);
    send4(4'b1111, 1'b1, 3'd4, 1'b0, 1'b1);
    send4(4'b0011, 1'b1, 3'd2, 1'b1, 1'b1);
    send4(4'b0111, 1'b1, 3'd3, 1'b0, 1'b1);
    send4(4'b0001, 1'b1, 3'd1, 1'b0, 1'b0);
    idle4(3);

    chk("q5_drained", q5.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
